flick_conditioner: RTL and testbench
====================================

FLICK_CONDITIONER -- requirements
Module: flick_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized cycles needed to accept a level change (legal 1..255).
REQ-002 SHALL have parameter REPEAT_DELAY, default 64, meaning PRESSED cycles before the first auto-repeat pulse (legal 2..255).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 16, meaning cycles between later auto-repeat pulses (legal 1..REPEAT_DELAY).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flick, input, 1 bit: raw asynchronous button level.
REQ-007 SHALL have port pulse_flick, output, 1 bit: registered one-cycle press pulse that drives the flasher's flick input.
REQ-008 SHALL have port flick_level, output, 1 bit: debounced button level.
REQ-009 SHALL have port cond_state, output, 2 bits: FSM state, encoded IDLE=0, DEB_PRESS=1, PRESSED=2, DEB_RELEASE=3.
REQ-010 SHALL have port press_count, output, 8 bits: count of pulse_flick assertions.

Function
REQ-011 SHALL pass flick through a 2-FF synchronizer; the FSM uses only the second-stage value (sync).
REQ-012 SHALL move IDLE->DEB_PRESS when sync=1, clearing the 8-bit debounce counter cnt to 0.
REQ-013 SHALL, in DEB_PRESS: return to IDLE if sync=0; go to PRESSED if sync=1 and cnt==DEBOUNCE_CYCLES-1; otherwise increment cnt.
REQ-014 SHALL assert pulse_flick for exactly one cycle, registered on the same edge as the DEB_PRESS->PRESSED transition.
REQ-015 SHALL, for flick first sampled high at edge k and held, raise pulse_flick after edge k+DEBOUNCE_CYCLES+2 and drop it after the next edge.
REQ-016 SHALL move PRESSED->DEB_RELEASE when sync=0, clearing cnt.
REQ-017 SHALL, in DEB_RELEASE: return to PRESSED with no pulse if sync=1; go to IDLE if sync=0 and cnt==DEBOUNCE_CYCLES-1; otherwise increment cnt.
REQ-018 SHALL drive flick_level=1 exactly in PRESSED and DEB_RELEASE.
REQ-019 SHALL increment press_count on every pulse_flick cycle, wrapping 255->0.
REQ-020 SHALL never assert pulse_flick for two consecutive cycles.

Reset
REQ-021 SHALL, while reset=0, immediately force pulse_flick=0, flick_level=0, cond_state=IDLE, press_count=0, cnt=0, repeat counter=0 and both synchronizer FFs=0, regardless of clk.
REQ-022 SHALL treat reset release mid-press as a fresh start: a held flick SHALL need a full debounce and SHALL produce a new pulse.

Configuration
REQ-023 SHALL, with macro FLICK_AUTOREPEAT_EN defined, run an 8-bit repeat counter that clears on entry to PRESSED, counts every PRESSED cycle, and emits extra pulses per REQ-024 and REQ-025.
REQ-024 SHALL emit the first auto-repeat pulse when REPEAT_DELAY cycles have elapsed in PRESSED.
REQ-025 SHALL emit each later auto-repeat pulse after a further REPEAT_PERIOD cycles, until PRESSED is left.
REQ-026 SHALL count auto-repeat pulses in press_count.
REQ-027 SHALL clear the repeat timing in DEB_RELEASE; re-entry to PRESSED restarts from 0 with no immediate pulse.
REQ-028 SHALL, without FLICK_AUTOREPEAT_EN, omit the repeat counter entirely and emit exactly one pulse per accepted press.

Verification (DEBOUNCE_CYCLES=4, 10-unit clock)
REQ-029 SHALL check reset=0 at time 0, with flick toggled during reset -> all outputs 0, cond_state=0, with no pulse after release.
REQ-030 SHALL check flick high for 2 cycles -> cond_state goes 0->1->0, no pulse_flick, press_count=0.
REQ-031 SHALL check flick held 20 cycles -> exactly one 1-cycle pulse at edge k+6, flick_level=1, press_count=1; after release flick_level=0 by edge k'+6.
REQ-032 SHALL check flick low for 1 cycle inside a held press -> DEB_RELEASE->PRESSED, no second pulse, press_count unchanged.
REQ-033 SHALL check 256 clean presses -> press_count wraps to 0, and reset=0 asserted mid-DEB_PRESS -> immediate IDLE.
REQ-034 SHALL check, with FLICK_AUTOREPEAT_EN and flick held in PRESSED for 100 cycles -> pulses at PRESSED cycles 0, 64, 80, 96, press_count=4.

Source files
------------

// File: rtl/flick_conditioner.sv
// Button conditioner: 2-FF sync, debounce FSM, one-cycle press pulse and press counter.
// Optional auto-repeat while held is enabled with the FLICK_AUTOREPEAT_EN macro.
module flick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flick,
    output logic       pulse_flick,
    output logic       flick_level,
    output logic [1:0] cond_state,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_DELAY < 2 || REPEAT_DELAY > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("flick_conditioner: illegal parameter combination");
    end

    state_t     r_state, w_next;
    logic       r_sync1, r_sync2;
    logic [7:0] r_cnt;
    logic       r_pulse;
    logic [7:0] r_press_count;
    logic       w_cnt_clr, w_cnt_inc, w_press_edge, w_rpt_hit, w_pulse_d;

    // State register (plus synchronizer and debounce counter)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_sync1 <= flick;
            r_sync2 <= r_sync1;
            r_state <= w_next;
            if (w_cnt_clr)      r_cnt <= 8'd0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next       = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_press_edge = 1'b0;
        case (r_state)
            IDLE: if (r_sync2) begin
                w_next    = DEB_PRESS;
                w_cnt_clr = 1'b1;
            end
            DEB_PRESS: begin
                if (!r_sync2)              w_next = IDLE;
                else if (r_cnt == DEB_LAST) begin
                    w_next       = PRESSED;
                    w_press_edge = 1'b1;
                end else                   w_cnt_inc = 1'b1;
            end
            PRESSED: if (!r_sync2) begin
                w_next    = DEB_RELEASE;
                w_cnt_clr = 1'b1;
            end
            DEB_RELEASE: begin
                if (r_sync2)               w_next = PRESSED;
                else if (r_cnt == DEB_LAST) w_next = IDLE;
                else                       w_cnt_inc = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef FLICK_AUTOREPEAT_EN
    logic [7:0] r_rpt;
    logic [7:0] w_rpt_nxt;
    assign w_rpt_nxt = r_rpt + 8'd1;
    assign w_rpt_hit = (r_state == PRESSED) && (w_next == PRESSED) && (w_rpt_nxt == 8'(REPEAT_DELAY));

    // Counts cycles spent in PRESSED; on a hit it rewinds so the next hit is REPEAT_PERIOD later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        r_rpt <= 8'd0;
        else if (r_state != PRESSED || w_next != PRESSED)  r_rpt <= 8'd0;
        else if (w_rpt_hit)                                r_rpt <= 8'(REPEAT_DELAY - REPEAT_PERIOD);
        else                                               r_rpt <= w_rpt_nxt;
    end
`else
    assign w_rpt_hit = 1'b0;
`endif

    // Output logic; back-to-back pulses are suppressed
    always_comb begin
        w_pulse_d   = (w_press_edge || w_rpt_hit) && !r_pulse;
        flick_level = (r_state == PRESSED) || (r_state == DEB_RELEASE);
        cond_state  = r_state;
        pulse_flick = r_pulse;
        press_count = r_press_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pulse       <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_pulse <= w_pulse_d;
            if (w_pulse_d) r_press_count <= r_press_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed self-checking bench for flick_conditioner (DEBOUNCE_CYCLES=4, 10-unit clock).
// Auto-repeat expectations follow FLICK_AUTOREPEAT_EN when it is defined.
module tb_flick_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       flick;
    logic       pulse_flick;
    logic       flick_level;
    logic [1:0] cond_state;
    logic [7:0] press_count;

    int   tests  = 0;
    int   fails  = 0;
    int   pulses = 0;
    int   consec = 0;
    int   p0     = 0;
    logic prev_p = 1'b0;

    flick_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(64), .REPEAT_PERIOD(16)) dut (
        .clk(clk), .reset(reset), .flick(flick),
        .pulse_flick(pulse_flick), .flick_level(flick_level),
        .cond_state(cond_state), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 unit after each edge and tallying pulses
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (pulse_flick === 1'b1) begin
                pulses++;
                if (prev_p) consec++;
            end
            prev_p = (pulse_flick === 1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;
        flick = 1'b0;
        #1;
        chk("rst_t0_pulse", 32'(pulse_flick), 0);
        chk("rst_t0_level", 32'(flick_level), 0);
        chk("rst_t0_state", 32'(cond_state), 0);
        chk("rst_t0_count", 32'(press_count), 0);
        repeat (6) begin
            flick = ~flick;
            tick(1);
        end
        chk("rst_toggle_state", 32'(cond_state), 0);
        chk("rst_toggle_pulse", 32'(pulses), 0);
        flick = 1'b0;
        reset = 1'b1;
        tick(10);
        chk("post_rst_nopulse", 32'(pulses), 0);
        chk("post_rst_state", 32'(cond_state), 0);

        // 2-cycle glitch: 0 -> DEB_PRESS -> 0, no pulse
        p0 = pulses;
        flick = 1'b1;
        tick(2);
        chk("glitch_s0", 32'(cond_state), 0);
        flick = 1'b0;
        tick(1);
        chk("glitch_s1", 32'(cond_state), 1);
        tick(4);
        chk("glitch_back_idle", 32'(cond_state), 0);
        chk("glitch_nopulse", 32'(pulses - p0), 0);
        chk("glitch_count", 32'(press_count), 0);

        // Held 20 cycles: pulse after edge k+6 only
        p0 = pulses;
        flick = 1'b1;
        tick(6);
        chk("hold_k5_pulse", 32'(pulse_flick), 0);
        chk("hold_k5_state", 32'(cond_state), 1);
        tick(1);
        chk("hold_k6_pulse", 32'(pulse_flick), 1);
        chk("hold_k6_state", 32'(cond_state), 2);
        chk("hold_k6_level", 32'(flick_level), 1);
        chk("hold_k6_count", 32'(press_count), 1);
        tick(1);
        chk("hold_k7_pulse", 32'(pulse_flick), 0);
        tick(12);
        chk("hold_one_pulse", 32'(pulses - p0), 1);
        flick = 1'b0;
        tick(6);
        chk("rel_k5_level", 32'(flick_level), 1);
        tick(1);
        chk("rel_k6_level", 32'(flick_level), 0);
        chk("rel_k6_state", 32'(cond_state), 0);

        // 1-cycle dropout inside a held press
        flick = 1'b1;
        tick(10);
        chk("drop_pre_count", 32'(press_count), 2);
        p0 = pulses;
        flick = 1'b0;
        tick(1);
        flick = 1'b1;
        tick(1);
        chk("drop_t2_state", 32'(cond_state), 2);
        tick(1);
        chk("drop_t3_state", 32'(cond_state), 3);
        tick(1);
        chk("drop_t4_state", 32'(cond_state), 2);
        tick(5);
        chk("drop_nopulse", 32'(pulses - p0), 0);
        chk("drop_count", 32'(press_count), 2);
        flick = 1'b0;
        tick(8);
        chk("drop_idle", 32'(cond_state), 0);

        // Reset asserted mid-DEB_PRESS, then fresh debounce with flick still held
        flick = 1'b1;
        tick(3);
        chk("mid_deb_state", 32'(cond_state), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(cond_state), 0);
        chk("async_rst_count", 32'(press_count), 0);
        chk("async_rst_level", 32'(flick_level), 0);
        chk("async_rst_pulse", 32'(pulse_flick), 0);
        tick(1);
        chk("rst_held_state", 32'(cond_state), 0);
        reset = 1'b1;
        p0 = pulses;
        tick(6);
        chk("fresh_k5_pulse", 32'(pulse_flick), 0);
        chk("fresh_k5_state", 32'(cond_state), 1);
        tick(1);
        chk("fresh_k6_pulse", 32'(pulse_flick), 1);
        chk("fresh_k6_count", 32'(press_count), 1);
        flick = 1'b0;
        tick(8);
        repeat (255) begin
            flick = 1'b1;
            tick(8);
            flick = 1'b0;
            tick(8);
        end
        chk("wrap_pulses", 32'(pulses - p0), 256);
        chk("wrap_count", 32'(press_count), 0);

        // Long hold: auto-repeat pulses only when the feature is built in
        flick = 1'b1;
        tick(7);
        chk("long_c0_pulse", 32'(pulse_flick), 1);
        p0 = pulses;
        tick(63);
        chk("long_c63_pulse", 32'(pulse_flick), 0);
        tick(1);
`ifdef FLICK_AUTOREPEAT_EN
        chk("long_c64_pulse", 32'(pulse_flick), 1);
        tick(16);
        chk("long_c80_pulse", 32'(pulse_flick), 1);
        tick(19);
        chk("long_pulses", 32'(pulses - p0), 3);
        chk("long_count", 32'(press_count), 4);
`else
        chk("long_c64_pulse", 32'(pulse_flick), 0);
        tick(16);
        chk("long_c80_pulse", 32'(pulse_flick), 0);
        tick(19);
        chk("long_pulses", 32'(pulses - p0), 0);
        chk("long_count", 32'(press_count), 1);
`endif
        chk("long_state", 32'(cond_state), 2);
        flick = 1'b0;
        tick(8);
        chk("no_consec_pulse", 32'(consec), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
